phase_sequencer: RTL and testbench

- Clocked successor to the combinational 8-phase instruction decoder; owns its own 3-bit phase counter.
- Parametrised opcode width.
- Adds a memory-ready handshake with stall and timeout, a HALTED state with resume, and sticky error flags.
- Sits between the instruction register, accumulator zero flag and memory on one side, and the datapath load/enable strobes on the other.

---
 rtl/phase_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Clocked 8-phase instruction sequencer with memory-ready stall/timeout, HALTED state and sticky errors.
// Optional single-step input enabled by defining PHASE_SEQ_SINGLE_STEP_EN.
module phase_sequencer #(
   parameter int unsigned OPC_W       = 3,
   parameter int unsigned RDY_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   input  logic             mem_rdy,
   input  logic             go,
`ifdef PHASE_SEQ_SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             halt,
   output logic             ld_pc,
   output logic             data_e,
   output logic             ld_ac,
   output logic             wr,
   output logic [2:0]       phase,
   output logic             halted,
   output logic             err_illegal,
   output logic             err_timeout
);

   // A zero-width counter is not legal, so keep one bit when the timeout is disabled
   localparam int unsigned CNT_W = (RDY_TIMEOUT > 0) ? $clog2(RDY_TIMEOUT + 1) : 1;

   typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_phase, w_phase_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_err_illegal, w_err_illegal_nxt;
   logic             r_err_timeout, w_err_timeout_nxt;
   logic             r_step, w_step_nxt;

   logic       w_legal;
   logic [2:0] w_op3;
   logic       w_h, w_a, w_z, w_j, w_s;
   logic       w_stall, w_timeout;

   assign w_op3 = opcode[2:0];

   if (OPC_W > 3) begin : g_wide_opc
      assign w_legal = (opcode[OPC_W-1:3] == '0);
   end else begin : g_narrow_opc
      assign w_legal = 1'b1;
   end

   assign w_h = w_legal & (w_op3 == 3'd0);
   assign w_a = w_legal & (w_op3 >= 3'd2) & (w_op3 <= 3'd5);
   assign w_z = w_legal & (w_op3 == 3'd1) & zero;
   assign w_j = w_legal & (w_op3 == 3'd7);
   assign w_s = w_legal & (w_op3 == 3'd6);

   assign w_stall = (r_state == S_RUN) & ~mem_rdy &
                    ((r_phase == 3'd1) | ((r_phase == 3'd5) & w_a) | ((r_phase == 3'd7) & w_s));
   assign w_timeout = w_stall & (RDY_TIMEOUT != 0) & (r_cnt == CNT_W'(RDY_TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_RUN;
         r_phase       <= 3'd0;
         r_cnt         <= '0;
         r_err_illegal <= 1'b0;
         r_err_timeout <= 1'b0;
         r_step        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_phase       <= w_phase_nxt;
         r_cnt         <= w_cnt_nxt;
         r_err_illegal <= w_err_illegal_nxt;
         r_err_timeout <= w_err_timeout_nxt;
         r_step        <= w_step_nxt;
      end
   end

   // Next state: halting events leave phase at 0 so a resume restarts a fetch
   always_comb begin
      w_state_nxt       = r_state;
      w_phase_nxt       = r_phase;
      w_cnt_nxt         = '0;
      w_err_illegal_nxt = r_err_illegal;
      w_err_timeout_nxt = r_err_timeout;
      w_step_nxt        = r_step;
      case (r_state)
         S_RUN: begin
            if ((r_phase == 3'd4) && !w_legal) begin
               w_state_nxt       = S_HALTED;
               w_phase_nxt       = 3'd0;
               w_err_illegal_nxt = 1'b1;
               w_step_nxt        = 1'b0;
            end else if ((r_phase == 3'd4) && w_h) begin
               w_state_nxt = S_HALTED;
               w_phase_nxt = 3'd0;
               w_step_nxt  = 1'b0;
            end else if (w_timeout) begin
               w_state_nxt       = S_HALTED;
               w_phase_nxt       = 3'd0;
               w_err_timeout_nxt = 1'b1;
               w_step_nxt        = 1'b0;
            end else if (w_stall) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
               w_phase_nxt = r_phase + 3'd1;
               if ((r_phase == 3'd7) && r_step) begin
                  w_state_nxt = S_HALTED;
                  w_step_nxt  = 1'b0;
               end
            end
         end
         S_HALTED: begin
            w_phase_nxt = 3'd0;
            if (!r_err_illegal && !r_err_timeout) begin
               if (go) begin
                  w_state_nxt = S_RUN;
                  w_step_nxt  = 1'b0;
               end
`ifdef PHASE_SEQ_SINGLE_STEP_EN
               else if (step) begin
                  w_state_nxt = S_RUN;
                  w_step_nxt  = 1'b1;
               end
`endif
            end
         end
         default: begin
            w_state_nxt = S_HALTED;
            w_phase_nxt = 3'd0;
         end
      endcase
   end

   // Datapath strobes decoded from the current phase; silent while halted
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (r_state == S_RUN) begin
         case (r_phase)
            3'd0: sel = 1'b1;
            3'd1: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            3'd2, 3'd3: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            3'd4: begin
               inc_pc = 1'b1;
               halt   = w_h;
            end
            3'd5: rd = w_a;
            3'd6: begin
               rd     = w_a;
               inc_pc = w_z;
               ld_pc  = w_j;
               data_e = w_s;
            end
            default: begin
               rd     = w_a;
               ld_pc  = w_j;
               data_e = w_s;
               ld_ac  = w_a;
               wr     = w_s;
            end
         endcase
      end
   end

   assign phase       = r_phase;
   assign halted      = (r_state == S_HALTED);
   assign err_illegal = r_err_illegal;
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a reference model queues the expected outputs for
// every driven cycle and a negedge monitor compares them against the DUT.
module tb_phase_sequencer;

   localparam int unsigned OPC_W = 4;
   localparam int unsigned TO    = 15;
   localparam logic [14:0] RST_VAL = {3'd0, 3'b000, 9'b1_0000_0000};

   logic             clk;
   logic             rst_n;
   logic [OPC_W-1:0] opcode;
   logic             zero, mem_rdy, go;
   logic             sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic [2:0]       phase;
   logic             halted, err_illegal, err_timeout;

   typedef struct {
      string       tag;
      logic [14:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int m_phase;
   int m_cnt;
   bit m_halted, m_eil, m_eto;

   phase_sequencer #(.OPC_W(OPC_W), .RDY_TIMEOUT(TO)) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy), .go(go),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt), .ld_pc(ld_pc),
      .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase), .halted(halted),
      .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [14:0] pack_dut();
      return {phase, halted, err_illegal, err_timeout,
              sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
   endfunction

   // Strobe table in order {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
   function automatic logic [8:0] ref_strobes(input int ph, input int op, input bit z);
      bit fh, fa, fz, fj, fs;
      fh = (op == 0);
      fa = (op >= 2) && (op <= 5);
      fz = (op == 1) && z;
      fj = (op == 7);
      fs = (op == 6);
      case (ph)
         0:       return 9'b1_0000_0000;
         1:       return 9'b1_1000_0000;
         2, 3:    return 9'b1_1100_0000;
         4:       return {3'b000, 1'b1, fh, 4'b0000};
         5:       return {1'b0, fa, 7'b0};
         6:       return {1'b0, fa, 1'b0, fz, 1'b0, fj, fs, 2'b00};
         default: return {1'b0, fa, 3'b000, fj, fs, fa, fs};
      endcase
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_cnt    = 0;
      m_halted = 1'b0;
      m_eil    = 1'b0;
      m_eto    = 1'b0;
   endtask

   // Drive one cycle at posedge+1, queue its expectation, advance the model, wait for the next edge
   task automatic cycle(input int op, input bit z, input bit rdy, input bit g, input string tag);
      exp_t e;
      bit   fa, fs, stall;
      opcode  = OPC_W'(op);
      zero    = z;
      mem_rdy = rdy;
      go      = g;
      e.tag = tag;
      e.val = {3'(m_phase), m_halted, m_eil, m_eto,
               m_halted ? 9'b0 : ref_strobes(m_phase, op, z)};
      exp_q.push_back(e);
      fa = (op >= 2) && (op <= 5);
      fs = (op == 6);
      if (m_halted) begin
         m_cnt   = 0;
         m_phase = 0;
         if (!m_eil && !m_eto && g) m_halted = 1'b0;
      end else if (m_phase == 4 && op >= 8) begin
         m_halted = 1'b1;
         m_eil    = 1'b1;
         m_phase  = 0;
         m_cnt    = 0;
      end else if (m_phase == 4 && op == 0) begin
         m_halted = 1'b1;
         m_phase  = 0;
         m_cnt    = 0;
      end else begin
         stall = !rdy && ((m_phase == 1) || (m_phase == 5 && fa) || (m_phase == 7 && fs));
         if (stall && m_cnt == int'(TO)) begin
            m_halted = 1'b1;
            m_eto    = 1'b1;
            m_phase  = 0;
            m_cnt    = 0;
         end else if (stall) begin
            m_cnt++;
         end else begin
            m_cnt   = 0;
            m_phase = (m_phase + 1) % 8;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // One instruction from phase 0, with mem_rdy held low for 'slen' cycles in phase 'sph'
   task automatic run_instr(input int op, input bit z, input int sph, input int slen, input string tag);
      int done_stall;
      done_stall = 0;
      for (int i = 0; i < 8 + slen; i++) begin
         if (m_phase == sph && done_stall < slen) begin
            done_stall++;
            cycle(op, z, 1'b0, 1'b0, tag);
         end else begin
            cycle(op, z, 1'b1, 1'b0, tag);
         end
      end
   endtask

   task automatic async_reset(input string tag);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq(tag, pack_dut(), RST_VAL);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq(e.tag, pack_dut(), e.val);
      end
   end

   initial begin
      int n;
      rst_n   = 1'b0;
      opcode  = '0;
      zero    = 1'b0;
      mem_rdy = 1'b1;
      go      = 1'b0;
      model_reset();
      #3;
      check_eq("reset", pack_dut(), RST_VAL);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_instr(2, 1'b0, -1, 0, "add");
      run_instr(2, 1'b0, -1, 0, "add2");

      run_instr(0, 1'b0, -1, 0, "hlt");
      for (int i = 0; i < 3; i++) cycle(0, 1'b0, 1'b1, 1'b0, "hlt_wait");
      check_eq("hlt_halted", 15'({phase, halted}), 15'({3'd0, 1'b1}));
      cycle(2, 1'b0, 1'b1, 1'b1, "go");
      run_instr(2, 1'b0, -1, 0, "resume");

      run_instr(6, 1'b0, 7, 3, "sto_stall");
      run_instr(5, 1'b0, 5, 2, "lda_stall");
      run_instr(6, 1'b0, 1, 2, "fetch_stall");
      run_instr(1, 1'b1, -1, 0, "skz_z1");
      run_instr(1, 1'b0, -1, 0, "skz_z0");
      run_instr(7, 1'b0, -1, 0, "jmp");
      run_instr(3, 1'b1, -1, 0, "and");
      run_instr(4, 1'b0, -1, 0, "xor");
      check_eq("no_err", 15'({err_illegal, err_timeout}), 15'd0);

      n = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle(2, 1'b0, 1'b0, 1'b0, "timeout");
         n = i;
         if (halted) break;
      end
      check_eq("timeout_len", 15'(n), 15'(TO + 2));
      for (int i = 0; i < 3; i++) cycle(2, 1'b0, 1'b1, 1'b1, "to_go_ignored");
      check_eq("to_flags", 15'({halted, err_timeout, err_illegal}), 15'(3'b110));
      async_reset("rst_clears_to");

      run_instr(9, 1'b0, -1, 0, "illegal");
      check_eq("ill_flags", 15'({halted, err_illegal, err_timeout}), 15'(3'b110));
      for (int i = 0; i < 3; i++) cycle(2, 1'b0, 1'b1, 1'b1, "ill_go_ignored");
      async_reset("rst_clears_ill");

      for (int i = 0; i < 5; i++) cycle(2, 1'b0, 1'b1, 1'b0, "pre_rst");
      check_eq("at_phase5", 15'(phase), 15'd5);
      async_reset("rst_mid_p5");
      run_instr(2, 1'b0, -1, 0, "post_rst");

      @(negedge clk);
      #1;
      check_eq("queue_drained", 15'(exp_q.size()), 15'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
